csc_arbiter: RTL and testbench

CSC_ARBITER -- requirements
Module: csc_arbiter

---
 rtl/csc_arbiter.sv | 143 ++++++++++++++
 tb/tb_csc_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/csc_arbiter.sv
// Two-requester arbiter in front of a shared colour-space converter.
// Credit-limited in-flight tracking feeds an ordered output FIFO.
module csc_arbiter #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned BURST = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [23:0] req0_pix,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [23:0] req1_pix,
  output logic [7:0]  cv_r,
  output logic [7:0]  cv_g,
  output logic [7:0]  cv_b,
  input  logic [7:0]  cv_y,
  input  logic [7:0]  cv_cb,
  input  logic [7:0]  cv_cr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_ycc,
  output logic        out_id,
  output logic        busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

  state_t        state;
  logic          last_id;
  logic [3:0]    burst_cnt;
  logic [4:0]    cnt_inc;
  logic [LAT:0]  pv;
  logic [LAT:0]  pid;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [24:0]   mem [DEPTH];

  logic        credit_ok;
  logic        accept;
  logic        acc_id;
  logic [23:0] acc_pix;
  logic        own_valid;
  logic        other_valid;
  state_t      other_state;
  logic        push;
  logic        pop;

  // Registered counts only: a pop in this cycle frees its slot next cycle.
  always_comb begin
    credit_ok   = (SW'(fifo_count) + SW'(inflight_cnt)) < SW'(DEPTH);
    req0_ready  = (state == SERVE0) && credit_ok;
    req1_ready  = (state == SERVE1) && credit_ok;
    accept      = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    acc_id      = (state == SERVE1);
    acc_pix     = acc_id ? req1_pix : req0_pix;
    own_valid   = acc_id ? req1_valid : req0_valid;
    other_valid = acc_id ? req0_valid : req1_valid;
    other_state = acc_id ? SERVE0 : SERVE1;
    cnt_inc     = {1'b0, burst_cnt} + 5'd1;
    push        = pv[LAT];
    out_valid   = (fifo_count != '0);
    pop         = out_valid && out_ready;
    out_ycc     = out_valid ? mem[rd_ptr][23:0] : '0;
    out_id      = out_valid ? mem[rd_ptr][24] : 1'b0;
    busy        = (fifo_count != '0) || (inflight_cnt != '0);
  end

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      burst_cnt <= '0;
      cv_r      <= '0;
      cv_g      <= '0;
      cv_b      <= '0;
    end else begin
      if (accept) begin
        cv_r    <= acc_pix[23:16];
        cv_g    <= acc_pix[15:8];
        cv_b    <= acc_pix[7:0];
        last_id <= acc_id;
      end
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (req0_valid && (!req1_valid || last_id)) state <= SERVE0;
          else if (req1_valid)                        state <= SERVE1;
        end
        SERVE0, SERVE1: begin
          if (!own_valid) begin
            burst_cnt <= '0;
            state     <= other_valid ? other_state : IDLE;
          end else if (accept) begin
            // Count saturates at BURST so a late-arriving rival still gets a turn.
            if (cnt_inc >= 5'(BURST) && other_valid) begin
              state     <= other_state;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= (cnt_inc >= 5'(BURST)) ? 4'(BURST) : cnt_inc[3:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv           <= '0;
      pid          <= '0;
      inflight_cnt <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      pv           <= {pv[LAT-1:0], accept};
      pid          <= {pid[LAT-1:0], acc_id};
      inflight_cnt <= inflight_cnt + CW'(accept) - CW'(push);
      fifo_count   <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pid[LAT], cv_y, cv_cb, cv_cr};
  end

endmodule

// File: tb/tb_csc_arbiter.sv
// Directed bench for csc_arbiter with a behavioural converter and an
// expected-beat queue checked by an independent output monitor.
module tb_csc_arbiter;
  localparam int unsigned LAT   = 1;
  localparam int unsigned BURST = 4;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [23:0] req0_pix, req1_pix;
  logic [7:0]  cv_r, cv_g, cv_b;
  logic [7:0]  cv_y = '0, cv_cb = '0, cv_cr = '0;
  logic        out_valid, out_ready, out_id, busy;
  logic [23:0] out_ycc;

  always #5 clk = ~clk;

  csc_arbiter #(.LAT(LAT), .BURST(BURST), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pix(req0_pix),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pix(req1_pix),
    .cv_r(cv_r), .cv_g(cv_g), .cv_b(cv_b),
    .cv_y(cv_y), .cv_cb(cv_cb), .cv_cr(cv_cr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ycc(out_ycc),
    .out_id(out_id), .busy(busy)
  );

  function automatic logic [23:0] conv(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int y, cb, cr;
    y  = (46 * int'(r) + 157 * int'(g) + 15 * int'(b) + 4096) & 32'hFFFF;
    cb = (-25 * int'(r) - 86 * int'(g) + 112 * int'(b) + 32768) & 32'hFFFF;
    cr = (112 * int'(r) - 102 * int'(g) - 10 * int'(b) + 32768) & 32'hFFFF;
    return {8'(y >> 8), 8'(cb >> 8), 8'(cr >> 8)};
  endfunction

  always @(posedge clk) {cv_y, cv_cb, cv_cr} <= conv(cv_r, cv_g, cv_b);

  // Hand-computed conversions of white, black, red, green, blue.
  logic [23:0] pix_tab [5] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF};
  logic [23:0] ycc_tab [5] = '{24'hE98080, 24'h108080, 24'h3D67EF, 24'hAC2A1A, 24'h1EEF76};

  int          q0[$], q1[$];
  logic [24:0] exp_q[$];
  logic        acc_id_q[$];
  int          acc_cyc_q[$];
  int          cyc = 0;
  int          checks = 0, passes = 0;
  logic        a0, a1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k = 0;
    while (acc_id_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({name, "_accepts"}, 32'(acc_id_q.size() >= n), 32'd1);
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    check({name, "_drain"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  // Requester drivers: present queue head, advance on an observed handshake.
  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_pix = '0; req1_pix = '0;
    forever begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (a0) begin void'(q0.pop_front()); acc_id_q.push_back(1'b0); acc_cyc_q.push_back(cyc); end
      if (a1) begin void'(q1.pop_front()); acc_id_q.push_back(1'b1); acc_cyc_q.push_back(cyc); end
      req0_valid = (q0.size() != 0);
      req1_valid = (q1.size() != 0);
      req0_pix   = (q0.size() != 0) ? pix_tab[q0[0]] : '0;
      req1_pix   = (q1.size() != 0) ? pix_tab[q1[0]] : '0;
    end
  end

  // Output monitor: every presented beat must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got %h expected none", {out_id, out_ycc});
        end else begin
          check("out_beat", 32'({out_id, out_ycc}), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int b0[6]   = '{2, 3, 4, 0, 1, 2};
    int b1[6]   = '{3, 4, 0, 1, 2, 3};
    int bids[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    int dids[5]  = '{0, 0, 1, 1, 1};

    out_ready = 1'b1;
    repeat (3) tick();
    check("reset_outs", 32'({req0_ready, req1_ready, out_valid, out_id, busy, out_ycc}), 32'd0);
    rst = 1'b0;

    // Both requesters saturated: bursts of BURST, no idle between bursts.
    base = acc_id_q.size();
    for (int i = 0; i < 6; i++) begin q0.push_back(b0[i]); q1.push_back(b1[i]); end
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, ycc_tab[b0[i]]});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, ycc_tab[b1[i]]});
    for (int i = 4; i < 6; i++) exp_q.push_back({1'b0, ycc_tab[b0[i]]});
    for (int i = 4; i < 6; i++) exp_q.push_back({1'b1, ycc_tab[b1[i]]});
    wait_acc(base + 12, 60, "burst");
    for (int i = 0; i < 12; i++)
      if (acc_id_q.size() > base + i) check("burst_order", 32'(acc_id_q[base + i]), 32'(bids[i]));
    if (acc_cyc_q.size() >= base + 12) begin
      check("burst_rate", 32'(acc_cyc_q[base + 3] - acc_cyc_q[base]), 32'd3);
      check("switch01_gap", 32'(acc_cyc_q[base + 4] - acc_cyc_q[base + 3]), 32'd1);
      check("switch10_gap", 32'(acc_cyc_q[base + 8] - acc_cyc_q[base + 7]), 32'd1);
    end
    drain(40, "burst");

    // Single beats: latency LAT+1 into an empty FIFO.
    for (int k = 0; k < 2; k++) begin
      base = acc_id_q.size();
      q0.push_back(k);
      exp_q.push_back({1'b0, ycc_tab[k]});
      wait_acc(base + 1, 20, "latency");
      tick();
      check("lat_edge1_valid", 32'(out_valid), 32'd0);
      tick();
      check("lat_edge2_valid", 32'(out_valid), 32'd1);
      drain(20, "latency");
    end

    // Back-pressure: credit stops acceptance at DEPTH beats.
    out_ready = 1'b0;
    base = acc_id_q.size();
    for (int i = 0; i < 6; i++) begin q1.push_back(i % 5); exp_q.push_back({1'b1, ycc_tab[i % 5]}); end
    wait_acc(base + 4, 20, "stall");
    repeat (5) tick();
    check("stall_count", 32'(acc_id_q.size() - base), 32'd4);
    check("stall_ready", 32'(req1_ready), 32'd0);
    out_ready = 1'b1;
    wait_acc(base + 6, 30, "stall_resume");
    drain(30, "stall");

    // Requester 0 drops mid-burst: requester 1 served on the next cycle.
    base = acc_id_q.size();
    q0.push_back(1); q0.push_back(2);
    q1.push_back(3); q1.push_back(4); q1.push_back(0);
    exp_q.push_back({1'b0, ycc_tab[1]}); exp_q.push_back({1'b0, ycc_tab[2]});
    exp_q.push_back({1'b1, ycc_tab[3]}); exp_q.push_back({1'b1, ycc_tab[4]});
    exp_q.push_back({1'b1, ycc_tab[0]});
    wait_acc(base + 5, 30, "drop");
    for (int i = 0; i < 5; i++)
      if (acc_id_q.size() > base + i) check("drop_order", 32'(acc_id_q[base + i]), 32'(dids[i]));
    if (acc_cyc_q.size() >= base + 3)
      check("drop_switch_gap", 32'(acc_cyc_q[base + 2] - acc_cyc_q[base + 1]), 32'd2);
    drain(30, "drop");

    // Reset with two beats in flight and two queued: all discarded.
    out_ready = 1'b0;
    base = acc_id_q.size();
    for (int i = 0; i < 4; i++) begin q0.push_back(i); exp_q.push_back({1'b0, ycc_tab[i]}); end
    wait_acc(base + 4, 20, "midreset");
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("midreset_outs", 32'({req0_ready, req1_ready, out_valid, busy}), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    check("midreset_busy", 32'(busy), 32'd0);

    base = acc_id_q.size();
    q1.push_back(4);
    exp_q.push_back({1'b1, ycc_tab[4]});
    wait_acc(base + 1, 20, "after_reset");
    drain(20, "after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
